tx_tlp_arbiter: RTL and testbench

TX_TLP_ARBITER -- requirements
Module: tx_tlp_arbiter

---
 rtl/tx_tlp_arbiter.sv | 136 +++++++++++++
 tb/tb_tx_tlp_arbiter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_tlp_arbiter.sv
// tx_tlp_arbiter: two-source TLP arbiter feeding the PCIe core tx stream.
// Port 0 carries completions and port 1 carries requests. A granted port
// keeps the master stream until its TLP's tlast beat is accepted. One idle
// cycle separates TLPs, and each port counts the TLPs it has completed.
//
// state | meaning
// IDLE  | no owner, outputs quiet, arbitrating on incoming tvalid
// LOCK0 | port 0 owns the master stream until its tlast beat transfers
// LOCK1 | port 1 owns the master stream until its tlast beat transfers
`timescale 1ns/1ps
module tx_tlp_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_tkeep,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_tkeep,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  input  logic                  prio_mode,
  output logic [1:0]            grant,
  output logic [CNT_WIDTH-1:0]  pkt_count0,
  output logic [CNT_WIDTH-1:0]  pkt_count1
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_e               state_q, state_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] pkt_count0_q, pkt_count0_d;
  logic [CNT_WIDTH-1:0] pkt_count1_q, pkt_count1_d;

  // State, round-robin history and packet counters; synchronous reset.
  // last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      pkt_count0_q <= '0;
      pkt_count1_q <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      pkt_count0_q <= pkt_count0_d;
      pkt_count1_q <= pkt_count1_d;
    end
  end

  // Next-state: arbitrate in IDLE, release the lock only on an accepted tlast beat.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    pkt_count0_d = pkt_count0_q;
    pkt_count1_d = pkt_count1_q;
    case (state_q)
      IDLE: begin
        if (s0_tvalid && s1_tvalid) begin
          // Tie: strict priority favours port 0, otherwise alternate away from last owner.
          state_d = (prio_mode || last_grant_q) ? LOCK0 : LOCK1;
        end else if (s0_tvalid) begin
          state_d = LOCK0;
        end else if (s1_tvalid) begin
          state_d = LOCK1;
        end
      end
      LOCK0: begin
        if (s0_tvalid && m_tready && s0_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b0;
          pkt_count0_d = pkt_count0_q + CNT_ONE;
        end
      end
      LOCK1: begin
        if (s1_tvalid && m_tready && s1_tlast) begin
          state_d      = IDLE;
          last_grant_d = 1'b1;
          pkt_count1_d = pkt_count1_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath mux: the locked port passes straight through; everything is quiet in IDLE.
  always_comb begin
    m_tdata   = '0;
    m_tkeep   = '0;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    grant     = 2'b00;
    case (state_q)
      LOCK0: begin
        m_tdata   = s0_tdata;
        m_tkeep   = s0_tkeep;
        m_tvalid  = s0_tvalid;
        m_tlast   = s0_tlast;
        s0_tready = m_tready;
        grant     = 2'b01;
      end
      LOCK1: begin
        m_tdata   = s1_tdata;
        m_tkeep   = s1_tkeep;
        m_tvalid  = s1_tvalid;
        m_tlast   = s1_tlast;
        s1_tready = m_tready;
        grant     = 2'b10;
      end
      default: ;
    endcase
  end

  assign pkt_count0 = pkt_count0_q;
  assign pkt_count1 = pkt_count1_q;

endmodule

// File: tb/tb_tx_tlp_arbiter.sv
// Testbench for tx_tlp_arbiter: per-port beat scoreboards filled by the source
// drivers and drained by a master-side monitor, plus scenario tasks.
`timescale 1ns/1ps
module tb_tx_tlp_arbiter;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int CW = 16;
  localparam int CWS = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [DW-1:0] s0_tdata = '0, s1_tdata = '0;
  logic [KW-1:0] s0_tkeep = '0, s1_tkeep = '0;
  logic s0_tvalid = 1'b0, s1_tvalid = 1'b0, s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic s0_tready, s1_tready;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tvalid, m_tlast;
  logic m_tready = 1'b1;
  logic prio_mode = 1'b0;
  logic [1:0] grant;
  logic [CW-1:0] pkt_count0, pkt_count1;

  logic w_s0_tready, w_s1_tready, w_m_tvalid, w_m_tlast;
  logic [DW-1:0] w_m_tdata;
  logic [KW-1:0] w_m_tkeep;
  logic [1:0] w_grant;
  logic [CWS-1:0] w_pkt_count0, w_pkt_count1;

  beat_t q0[$];
  beat_t q1[$];
  int done_order[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats_seen0 = 0;
  int beats_seen1 = 0;

  tx_tlp_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready),
    .prio_mode(prio_mode), .grant(grant), .pkt_count0(pkt_count0), .pkt_count1(pkt_count1)
  );

  // Narrow-counter copy sharing all inputs, used to reach the counter wrap quickly.
  tx_tlp_arbiter #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .CNT_WIDTH(CWS)) dut_w (
    .clk(clk), .reset(reset),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(w_s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(w_s1_tready),
    .m_tdata(w_m_tdata), .m_tkeep(w_m_tkeep), .m_tvalid(w_m_tvalid), .m_tlast(w_m_tlast), .m_tready(m_tready),
    .prio_mode(prio_mode), .grant(w_grant), .pkt_count0(w_pkt_count0), .pkt_count1(w_pkt_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Monitor: every transferring master beat must match the owner's next expected beat.
  beat_t mon_exp, mon_act;
  logic  mon_ok;
  always @(negedge clk) begin
    if (!reset && m_tvalid && m_tready) begin
      mon_act = {m_tdata, m_tkeep, m_tlast};
      mon_ok  = 1'b1;
      mon_exp = '0;
      checks++;
      if (grant == 2'b01 && q0.size() > 0) begin
        mon_exp = q0.pop_front();
        beats_seen0++;
      end else if (grant == 2'b10 && q1.size() > 0) begin
        mon_exp = q1.pop_front();
        beats_seen1++;
      end else begin
        mon_ok = 1'b0;
        errors++;
        $display("FAIL mon_unexpected_beat grant=%b q0=%0d q1=%0d data=%h", grant, q0.size(), q1.size(), m_tdata);
      end
      if (mon_ok && mon_act !== mon_exp) begin
        errors++;
        $display("FAIL mon_beat got=%h exp=%h", mon_act, mon_exp);
      end
      if (m_tlast) done_order.push_back(grant == 2'b10 ? 1 : 0);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic drive(input int p, input logic v, input beat_t b);
    if (p == 0) begin
      s0_tvalid = v; s0_tdata = b.data; s0_tkeep = b.keep; s0_tlast = b.last;
    end else begin
      s1_tvalid = v; s1_tdata = b.data; s1_tkeep = b.keep; s1_tlast = b.last;
    end
  endtask

  // Source driver: offers nbeats beats, optionally dropping tvalid before beat drop_at.
  task automatic send_tlp(input int p, input int nbeats, input int drop_at, input int drop_len);
    beat_t b;
    logic  ok;
    for (int i = 0; i < nbeats; i++) begin
      if (i == drop_at && drop_len > 0) begin
        drive(p, 1'b0, '0);
        repeat (drop_len) @(posedge clk);
        #1;
      end
      b.data = {$urandom(), $urandom()};
      b.keep = 8'($urandom_range(1, 255));
      b.last = (i == nbeats - 1);
      drive(p, 1'b1, b);
      if (p == 0) q0.push_back(b); else q1.push_back(b);
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if ((p == 0) ? s0_tready : s1_tready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL handshake_timeout port=%0d beat=%0d got=no_tready exp=tready", p, i);
      end
      @(posedge clk);
      #1;
    end
    drive(p, 1'b0, '0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    done_order.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    @(negedge clk);
    checks++;
    if ({grant, m_tvalid, m_tlast, s0_tready, s1_tready} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b exp=000000", {grant, m_tvalid, m_tlast, s0_tready, s1_tready});
    end
    checks++;
    if ({m_tdata, m_tkeep} !== '0) begin
      errors++;
      $display("FAIL reset_data got=%h exp=0", {m_tdata, m_tkeep});
    end
    checks++;
    if (pkt_count0 !== 16'd0 || pkt_count1 !== 16'd0) begin
      errors++;
      $display("FAIL reset_counts got=%0d/%0d exp=0/0", pkt_count0, pkt_count1);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    apply_reset();
    prio_mode = 1'b0;
    fork
      begin for (int i = 0; i < 3; i++) send_tlp(0, 2, -1, 0); end
      begin for (int i = 0; i < 3; i++) send_tlp(1, 2, -1, 0); end
      begin
        for (int k = 0; k < 18; k++) begin
          @(negedge clk);
          if (k == 0) begin
            checks++;
            if (m_tvalid !== 1'b0 || m_tdata !== '0 || s0_tready !== 1'b0 || s1_tready !== 1'b0) begin
              errors++;
              $display("FAIL rr_idle_quiet got=v%b r%b%b exp=v0 r00", m_tvalid, s0_tready, s1_tready);
            end
          end
          if (k == 0) exp_g = 2'b00;
          else case ((k - 1) % 6)
            0, 1: exp_g = 2'b01;
            3, 4: exp_g = 2'b10;
            default: exp_g = 2'b00;
          endcase
          checks++;
          if (grant !== exp_g) begin
            errors++;
            $display("FAIL rr_grant cycle=%0d got=%b exp=%b", k, grant, exp_g);
          end
        end
      end
    join
    checks++;
    if (pkt_count0 !== 16'd3 || pkt_count1 !== 16'd3) begin
      errors++;
      $display("FAIL rr_counts got=%0d/%0d exp=3/3", pkt_count0, pkt_count1);
    end
    checks++;
    if (done_order.size() != 6) begin
      errors++;
      $display("FAIL rr_order_len got=%0d exp=6", done_order.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (done_order[i] != i % 2) begin
          errors++;
          $display("FAIL rr_order idx=%0d got=%0d exp=%0d", i, done_order[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_priority();
    beat_t b;
    apply_reset();
    prio_mode = 1'b1;
    fork
      begin for (int i = 0; i < 3; i++) send_tlp(0, 2, -1, 0); end
      begin
        b.data = {$urandom(), $urandom()};
        b.keep = 8'hFF;
        b.last = 1'b1;
        drive(1, 1'b1, b);
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          checks++;
          if (s1_tready !== 1'b0 || grant === 2'b10) begin
            errors++;
            $display("FAIL prio_s1_blocked cycle=%0d got=r%b g%b exp=r0", k, s1_tready, grant);
          end
        end
        @(posedge clk);
        #1;
        drive(1, 1'b0, '0);
      end
    join
    repeat (2) @(negedge clk);
    checks++;
    if (pkt_count0 !== 16'd3 || pkt_count1 !== 16'd0) begin
      errors++;
      $display("FAIL prio_counts got=%0d/%0d exp=3/0", pkt_count0, pkt_count1);
    end
  endtask

  task automatic test_stall();
    int seen_before;
    logic locked;
    apply_reset();
    prio_mode = 1'b0;
    seen_before = beats_seen1;
    fork
      send_tlp(1, 4, 2, 2);
      begin
        for (int i = 0; i < 20; i++) begin
          m_tready = (i % 2 == 0);
          @(posedge clk);
          #1;
        end
        m_tready = 1'b1;
      end
      begin
        locked = 1'b0;
        for (int t = 0; t < 20 && !locked; t++) begin
          @(negedge clk);
          locked = (grant == 2'b10);
        end
        checks++;
        if (!locked) begin
          errors++;
          $display("FAIL stall_lock got=%b exp=10", grant);
        end
        for (int t = 0; t < 60 && locked; t++) begin
          @(negedge clk);
          if (pkt_count1 == 16'd1) break;
          checks++;
          if (grant !== 2'b10) begin
            errors++;
            $display("FAIL stall_grant cycle=%0d got=%b exp=10", t, grant);
          end
        end
      end
    join
    checks++;
    if (beats_seen1 - seen_before != 4 || q1.size() != 0) begin
      errors++;
      $display("FAIL stall_beats got=%0d left=%0d exp=4 left=0", beats_seen1 - seen_before, q1.size());
    end
    checks++;
    if (pkt_count1 !== 16'd1) begin
      errors++;
      $display("FAIL stall_count got=%0d exp=1", pkt_count1);
    end
  endtask

  task automatic test_back_to_back();
    int t0;
    apply_reset();
    t0 = cyc;
    for (int i = 0; i < 5; i++) send_tlp(0, 1, -1, 0);
    checks++;
    if (cyc - t0 != 10) begin
      errors++;
      $display("FAIL b2b_cycles got=%0d exp=10", cyc - t0);
    end
    checks++;
    if (pkt_count0 !== 16'd5) begin
      errors++;
      $display("FAIL b2b_count got=%0d exp=5", pkt_count0);
    end
  endtask

  task automatic test_reset_mid();
    beat_t b;
    apply_reset();
    prio_mode = 1'b0;
    b.data = {$urandom(), $urandom()};
    b.keep = 8'hFF;
    b.last = 1'b0;
    drive(0, 1'b1, b);
    q0.push_back(b);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    b.data = {$urandom(), $urandom()};
    drive(0, 1'b1, b);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 1'b0, '0);
    @(negedge clk);
    checks++;
    if (grant !== 2'b00 || m_tvalid !== 1'b0 || pkt_count0 !== 16'd0) begin
      errors++;
      $display("FAIL midreset got=g%b v%b c%0d exp=g00 v0 c0", grant, m_tvalid, pkt_count0);
    end
    @(posedge clk);
    #1;
    fork
      send_tlp(0, 1, -1, 0);
      send_tlp(1, 1, -1, 0);
    join
    checks++;
    if (done_order.size() != 2 || done_order[0] != 0) begin
      errors++;
      $display("FAIL midreset_tie got=%0d exp=0", done_order.size() > 0 ? done_order[0] : -1);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 15; i++) send_tlp(0, 1, -1, 0);
    checks++;
    if (w_pkt_count0 !== 4'hF) begin
      errors++;
      $display("FAIL wrap_full got=%h exp=f", w_pkt_count0);
    end
    send_tlp(0, 1, -1, 0);
    checks++;
    if (w_pkt_count0 !== 4'h0 || w_pkt_count1 !== 4'h0) begin
      errors++;
      $display("FAIL wrap_zero got=%h/%h exp=0/0", w_pkt_count0, w_pkt_count1);
    end
    checks++;
    if (pkt_count0 !== 16'd16) begin
      errors++;
      $display("FAIL wrap_wide got=%0d exp=16", pkt_count0);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (pkt_count0 !== 16'd0 || w_pkt_count0 !== 4'h0) begin
      errors++;
      $display("FAIL reset_clears_count got=%0d/%0d exp=0/0", pkt_count0, w_pkt_count0);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_priority();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
